// File: rtl/bcm_pkg.sv
// rtl/bcm_pkg.sv - shared types and helpers for the BCM row sequencer
package bcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_BLANK,
    ST_SHOW,
    ST_STALL
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width for a count, never collapsing to zero bits.
  function automatic int idx_w(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  // On-time of one bit plane, in ticks.
  function automatic int plane_ticks(input int base_ticks, input int plane);
    return base_ticks << plane;
  endfunction

endpackage

// File: rtl/bcm_tick_gen.sv
// rtl/bcm_tick_gen.sv - tick prescaler with synchronous restart
module bcm_tick_gen
  import bcm_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = idx_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count clock cycles; held at zero while restart is high so the first tick lands TICK_DIV cycles later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/bcm_row_sequencer.sv
// rtl/bcm_row_sequencer.sv - bit-angle modulation row/plane sequencer with prefetch
module bcm_row_sequencer
  import bcm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BITS       = 12,
  parameter int ROWS       = 8,
  parameter int TICK_DIV   = 4,
  parameter int BASE_TICKS = 1,
  parameter int BLANK_CYC  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     load_rq,
  output logic [idx_w(ROWS)-1:0]   req_row,
  output logic [idx_w(BITS)-1:0]   req_bit,
  input  logic                     data_ready,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [idx_w(BITS)-1:0]   plane_bit,
  output logic                     blank,
  output logic                     latch,
  output logic                     frame_done,
  output logic                     underrun
);

  localparam int RW    = idx_w(ROWS);
  localparam int BW    = idx_w(BITS);
  localparam int BCW   = idx_w(BLANK_CYC);
  localparam int DUR_W = clog2(BASE_TICKS) + BITS;

  state_t              state, next_state;
  logic                req_pend, next_valid;
  logic [DATA_W-1:0]   next_buf, act_buf;
  logic [BCW-1:0]      blank_cnt;
  logic [DUR_W-1:0]    tick_cnt, dur_last;
  logic [RW-1:0]       succ_row;
  logic [BW-1:0]       succ_bit;
  logic                tick, accept, valid_eff, blank_last, expire, last_plane;
  logic                issue_rq, enter_blank;

  // A strobe only counts while a request is outstanding, including the cycle load_rq is raised.
  assign accept     = data_ready & (load_rq | req_pend);
  assign valid_eff  = next_valid | accept;
  assign blank_last = (blank_cnt == BCW'(BLANK_CYC - 1));
  assign dur_last   = DUR_W'(plane_ticks(BASE_TICKS, int'(plane_bit)) - 1);
  assign expire     = (state == ST_SHOW) & tick & (tick_cnt == dur_last);
  assign last_plane = (row == RW'(ROWS - 1)) && (plane_bit == BW'(BITS - 1));

  bcm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(state != ST_SHOW),
    .tick   (tick)
  );

  // Successor plane: next bit, then next row, wrapping the last row to 0.
  always_comb begin
    succ_row = row;
    succ_bit = plane_bit + 1'b1;
    if (plane_bit == BW'(BITS - 1)) begin
      succ_bit = '0;
      succ_row = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state  = state;
    issue_rq    = 1'b0;
    enter_blank = 1'b0;
    blank       = (state != ST_SHOW);
    data_out    = (state == ST_SHOW) ? act_buf : '0;
    latch       = (state == ST_BLANK) & blank_last;
    frame_done  = enable & expire & last_plane;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          next_state = ST_FIRST;
          issue_rq   = 1'b1;
        end
        ST_FIRST, ST_STALL: begin
          if (accept) begin
            next_state  = ST_BLANK;
            enter_blank = 1'b1;
          end
        end
        ST_BLANK: begin
          if (blank_last) begin
            next_state = ST_SHOW;
            issue_rq   = 1'b1;
          end
        end
        ST_SHOW: begin
          if (expire) begin
            enter_blank = valid_eff;
            next_state  = valid_eff ? ST_BLANK : ST_STALL;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Request handshake, plane buffers, counters and the sticky underrun flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_rq    <= 1'b0;
      req_row    <= '0;
      req_bit    <= '0;
      req_pend   <= 1'b0;
      next_buf   <= '0;
      next_valid <= 1'b0;
      act_buf    <= '0;
      row        <= '0;
      plane_bit  <= '0;
      blank_cnt  <= '0;
      tick_cnt   <= '0;
      underrun   <= 1'b0;
    end else if (!enable) begin
      load_rq    <= 1'b0;
      req_row    <= '0;
      req_bit    <= '0;
      req_pend   <= 1'b0;
      next_buf   <= '0;
      next_valid <= 1'b0;
      act_buf    <= '0;
      row        <= '0;
      plane_bit  <= '0;
      blank_cnt  <= '0;
      tick_cnt   <= '0;
      underrun   <= 1'b0;
    end else begin
      load_rq  <= issue_rq;
      req_pend <= (req_pend | load_rq) & ~data_ready;
      if (issue_rq) begin
        req_row <= (state == ST_IDLE) ? '0 : succ_row;
        req_bit <= (state == ST_IDLE) ? '0 : succ_bit;
      end
      if (accept) begin
        next_buf   <= data_in;
        next_valid <= 1'b1;
      end
      if (enter_blank) begin
        act_buf    <= accept ? data_in : next_buf;
        next_valid <= 1'b0;
        row        <= req_row;
        plane_bit  <= req_bit;
      end
      blank_cnt <= (state == ST_BLANK && !blank_last) ? blank_cnt + 1'b1 : '0;
      if (state != ST_SHOW) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= expire ? '0 : tick_cnt + 1'b1;
      end
      if (expire && !valid_eff) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcm_row_sequencer.sv
// tb/tb_bcm_row_sequencer.sv - scoreboard bench for bcm_row_sequencer
module tb_bcm_row_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       enable_b = 1'b0;

  logic       load_rq, blank, latch, frame_done, underrun;
  logic [0:0] req_row, row;
  logic [1:0] req_bit, plane_bit;
  logic       data_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  logic       load_rq_b, blank_b, latch_b, frame_done_b, underrun_b;
  logic [0:0] req_row_b, row_b;
  logic [1:0] req_bit_b, plane_bit_b;
  logic       data_ready_b = 1'b0;
  logic [7:0] data_in_b = 8'h5A;
  logic [7:0] data_out_b;

  always #5 clock = ~clock;

  bcm_row_sequencer #(
    .DATA_W(8), .BITS(4), .ROWS(2), .TICK_DIV(1), .BASE_TICKS(1), .BLANK_CYC(2)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .load_rq(load_rq), .req_row(req_row), .req_bit(req_bit),
    .data_ready(data_ready), .data_in(data_in),
    .data_out(data_out), .row(row), .plane_bit(plane_bit),
    .blank(blank), .latch(latch), .frame_done(frame_done), .underrun(underrun)
  );

  bcm_row_sequencer #(
    .DATA_W(8), .BITS(4), .ROWS(2), .TICK_DIV(3), .BASE_TICKS(2), .BLANK_CYC(2)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b),
    .load_rq(load_rq_b), .req_row(req_row_b), .req_bit(req_bit_b),
    .data_ready(data_ready_b), .data_in(data_in_b),
    .data_out(data_out_b), .row(row_b), .plane_bit(plane_bit_b),
    .blank(blank_b), .latch(latch_b), .frame_done(frame_done_b), .underrun(underrun_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired before the expected event", name);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_load_rq"}, load_rq, 0);
    check({tag, "_req_row"}, req_row, 0);
    check({tag, "_req_bit"}, req_bit, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_bit"}, plane_bit, 0);
    check({tag, "_blank"}, blank, 1);
    check({tag, "_latch"}, latch, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  // Expected SHOW of one plane: plane, data, length, preceding blank gap (-1 = unchecked), underrun seen.
  typedef struct {
    int         row;
    int         bit_i;
    logic [7:0] data;
    int         len;
    int         gap;
    logic       ur;
  } exp_t;

  exp_t sb[$];
  int   phase = 0;

  // Plane on-time in cycles for DUT A (TICK_DIV=1, BASE_TICKS=1).
  function automatic int plen(input int i);
    return 1 << (i % 4);
  endfunction

  // Response delay after load_rq, per request index: 2 -> exact expiry, 18 -> withheld.
  function automatic int delay_for(input int i);
    if (phase == 0 && i == 2) return 1;
    if (phase == 0 && i == 18) return 6;
    return 0;
  endfunction

  // Responder: answers each request for DUT A, pushing the plane it should show.
  int   r_idx = 0, r_cnt = 0, r_d = 0;
  logic r_pend = 1'b0;
  logic ur_model = 1'b0;
  int   pulse_req = 0, pulse_done = 0;

  always @(negedge clock) begin
    exp_t e;
    int   stall;
    data_ready = 1'b0;
    if (reset || !enable) begin
      r_pend   = 1'b0;
      r_idx    = 0;
      ur_model = 1'b0;
    end else begin
      if (load_rq) begin
        check("req_row", req_row, (r_idx / 4) % 2);
        check("req_bit", req_bit, r_idx % 4);
        r_pend = 1'b1;
        r_d    = delay_for(r_idx);
        r_cnt  = r_d;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          e.row   = (r_idx / 4) % 2;
          e.bit_i = r_idx % 4;
          e.data  = 8'hA0 + 8'(r_idx);
          e.len   = plen(r_idx);
          if (r_idx == 0) begin
            e.gap = -1;
          end else begin
            stall = r_d - (plen(r_idx - 1) - 1);
            if (stall < 0) stall = 0;
            if (stall > 0) ur_model = 1'b1;
            e.gap = 2 + stall;
          end
          e.ur = ur_model;
          sb.push_back(e);
          data_ready = 1'b1;
          data_in    = e.data;
          r_idx++;
          r_pend = 1'b0;
        end else begin
          r_cnt--;
        end
      end
    end
    if (pulse_req != pulse_done) begin
      data_ready = 1'b1;
      data_in    = 8'hEE;
      pulse_done++;
    end
  end

  // Monitor: measures each SHOW run and the blank gap before it, then compares against the scoreboard.
  int         planes_done = 0;
  int         m_len = 0, m_gap = -1, m_lat = 0, m_g = 0, m_l = 0, m_row = 0, m_bit = 0;
  logic       m_in = 1'b0, m_bad = 1'b0, m_gapbad = 1'b0, m_gb = 1'b0, m_fd = 1'b0;
  logic       m_prev_latch = 1'b0, m_lp = 1'b0, m_ur = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(negedge clock) begin
    exp_t e;
    if (reset || !enable) begin
      m_in     = 1'b0;
      m_gap    = -1;
      m_lat    = 0;
      m_gapbad = 1'b0;
      sb.delete();
    end else if (!blank) begin
      if (!m_in) begin
        m_in   = 1'b1;
        m_len  = 0;
        m_row  = int'(row);
        m_bit  = int'(plane_bit);
        m_data = data_out;
        m_ur   = underrun;
        m_fd   = 1'b0;
        m_bad  = 1'b0;
        m_g    = m_gap;
        m_l    = m_lat;
        m_lp   = m_prev_latch;
        m_gb   = m_gapbad;
      end
      m_len++;
      if (int'(row) != m_row || int'(plane_bit) != m_bit || data_out !== m_data) m_bad = 1'b1;
      if (frame_done) m_fd = 1'b1;
    end else begin
      if (m_in) begin
        if (sb.size() == 0) begin
          timeout_fail("scoreboard_empty_at_show_end");
        end else begin
          e = sb.pop_front();
          check("show_row", m_row, e.row);
          check("show_bit", m_bit, e.bit_i);
          check("show_data", m_data, e.data);
          check("show_len", m_len, e.len);
          check("show_stable", m_bad, 0);
          check("frame_done", m_fd, (e.row == 1 && e.bit_i == 3) ? 1 : 0);
          check("underrun", m_ur, e.ur);
          if (e.gap >= 0) begin
            check("gap_len", m_g, e.gap);
            check("latch_count", m_l, 1);
            check("latch_last_blank", m_lp, 1);
            check("gap_data_zero", m_gb, 0);
          end
        end
        planes_done++;
        m_in     = 1'b0;
        m_gap    = 0;
        m_lat    = 0;
        m_gapbad = 1'b0;
      end
      if (m_gap >= 0) m_gap++;
      if (data_out !== 8'h00) m_gapbad = 1'b1;
      if (latch) m_lat++;
    end
    m_prev_latch = latch;
  end

  // DUT B: answer every request on the same cycle and time its first four planes.
  int   b_exp[4] = '{6, 12, 24, 48};
  int   b_len = 0, b_done = 0, b_bit = 0;
  logic b_in = 1'b0;

  always @(negedge clock) begin
    data_ready_b = load_rq_b;
    if (!reset && enable_b) begin
      if (!blank_b) begin
        if (!b_in) begin
          b_in  = 1'b1;
          b_len = 0;
          b_bit = int'(plane_bit_b);
          check("b_data", data_out_b, 8'h5A);
        end
        b_len++;
      end else if (b_in) begin
        b_in = 1'b0;
        if (b_done < 4) begin
          check("b_bit", b_bit, b_done);
          check("b_len", b_len, b_exp[b_done]);
        end
        b_done++;
      end
    end
  end

  initial begin
    int n;
    int target;
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_idle("idle_disabled");
    enable   = 1'b1;
    enable_b = 1'b1;
    @(negedge clock);
    check("first_load_rq", load_rq, 1);
    check("first_req_row", req_row, 0);
    check("first_req_bit", req_bit, 0);

    n = 0;
    while (planes_done < 31 && n < 2000) begin @(negedge clock); n++; end
    if (planes_done < 31) timeout_fail("wait_31_planes");
    n = 0;
    while (blank !== 1'b0 && n < 50) begin @(negedge clock); n++; end
    if (blank !== 1'b0) timeout_fail("wait_show_1_3");
    repeat (3) @(negedge clock);
    check("abort_row", row, 1);
    check("abort_bit", plane_bit, 3);
    check("abort_blank", blank, 0);
    check("underrun_before_abort", underrun, 1);
    enable = 1'b0;
    @(negedge clock);
    check_idle("abort");
    pulse_req++;
    repeat (3) @(negedge clock);
    check_idle("ignored_ready");

    phase  = 1;
    enable = 1'b1;
    @(negedge clock);
    check("reenable_load_rq", load_rq, 1);
    check("reenable_req_row", req_row, 0);
    check("reenable_req_bit", req_bit, 0);
    target = planes_done + 1;
    n = 0;
    while (planes_done < target && n < 200) begin @(negedge clock); n++; end
    if (planes_done < target) timeout_fail("wait_plane_after_reenable");
    n = 0;
    while (b_done < 4 && n < 2000) begin @(negedge clock); n++; end
    if (b_done < 4) timeout_fail("wait_dut_b_planes");
    check("b_underrun", underrun_b, 0);

    n = 0;
    while (!(blank === 1'b1 && latch === 1'b0 && plane_bit !== 2'd0) && n < 200) begin
      @(negedge clock); n++;
    end
    check("pre_reset_blank", blank, 1);
    check("pre_reset_bit_nonzero", (plane_bit != 2'd0) ? 1 : 0, 1);
    #2 reset = 1'b1;
    #1 check_idle("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
